alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning edges from ALU operand load to ALU result registered.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports a_valid / b_valid, input, 1, requester A/B has an operation pending.
REQ-005 SHALL have ports a_ready / b_ready, output, 1, accept strobe; the transfer occurs when valid and ready are both high on an edge.
REQ-006 SHALL have ports a_rd, a_rr, a_op / b_rd, b_rr, b_op, input, 8 each, operands and ALU opcode.
REQ-007 SHALL have ports a_resp_valid / b_resp_valid, output, 1, response held for that requester.
REQ-008 SHALL have ports a_resp_ready / b_resp_ready, input, 1, requester consumes the response.
REQ-009 SHALL have shared ports resp_data (output, 16), resp_c, resp_n, resp_z and resp_err (output, 1 each), meaningful only while a *_resp_valid is high.
REQ-010 SHALL have ports alu_rd, alu_rr, alu_opcode (output, 8) and alu_ci (output, 1), all registered, driving the ALU inputs.
REQ-011 SHALL have ports alu_data (input, 16) and alu_co, alu_no, alu_zo (input, 1 each), the ALU registered results.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 In IDLE, SHALL grant one valid requester per cycle:
- Only one valid: grant it.
- Both valid: grant the one not granted last (round robin).
- Ready is asserted combinationally, only to the granted requester, and only in IDLE.
REQ-015 Legal opcodes SHALL be 0000xxxx, 0100xxxx, 1000xxxx, 1001xxxx, 1010xxxx, 1011xx00, 1100xxxx, 1101xxxx, 1110xxxx and 1111xxxx; every other opcode is illegal.
REQ-016 On accepting a legal opcode, SHALL on the same edge:
- Load alu_rd, alu_rr and alu_opcode from the granted requester.
- Load alu_ci from that requester's carry register.
- Load a counter with LATENCY and enter WAIT.
REQ-017 In WAIT, SHALL decrement the counter each edge; on the edge where the counter equals 0, SHALL capture the result and enter RESP:
- resp_data = alu_data; resp_c = alu_co; resp_n = alu_no; resp_z = alu_zo; resp_err = 0.
- The owner's carry register is loaded with alu_co.
REQ-018 For LATENCY=2, the response SHALL be valid after the 3rd edge following the accept edge.
REQ-019 On accepting an illegal opcode, SHALL respond without touching the ALU:
- alu_* registers are left unchanged.
- Next state is RESP, with resp_data=0, all flags 0, resp_err=1.
- The owner's carry register is unchanged.
REQ-020 In RESP, SHALL assert only the owner's *_resp_valid and hold the resp_* values stable until that requester's *_resp_ready is high on an edge; then enter IDLE.
REQ-021 SHALL NOT accept a new request in the cycle a response is consumed; IDLE lasts at least one cycle between operations.
REQ-022 SHALL ignore the non-owner's resp_ready; a deasserted valid from a waiting requester SHALL drop it with no side effect.
REQ-023 SHALL update the last-grant register only on accept.
REQ-024 SHALL keep the per-requester carry registers (carry_a, carry_b) independent, so carry chains (addc/subc) are not corrupted by interleaving.

Reset
REQ-025 On rst high, SHALL asynchronously reset as follows:
- state=IDLE, counter=0, busy=0.
- Both resp_valid=0, both ready=0.
- resp_data=0, all resp flags=0.
- alu_rd=alu_rr=alu_opcode=0, alu_ci=0.
- carry_a=carry_b=0.
- last-grant=B, so A wins the first contention.
REQ-026 Reset mid-WAIT or mid-RESP SHALL discard the operation and produce no response after reset is released.

Verification
REQ-027 A add (op 0xC0, 0x7F, 0x01) -> a_resp_valid 3 cycles after accept; resp_data=0x0080, n=1, z=0, c=0, err=0.
REQ-028 A mult (op 0x40, 0x10, 0x10) -> resp_data=0x0100, err=0.
REQ-029 a_valid and b_valid both high from reset, each with op 0xC0 -> A served first, B accepted in the first IDLE cycle after A's response is consumed; b_ready stays 0 until then.
REQ-030 Carry chain: A add 0xFF+0x01 -> data 0x0000, c=1, z=1. Then B add 0x01+0x01 (carry_b becomes 0). Then A addc (op 0xD0) 0x00+0x00 -> alu_ci=1, data 0x0001.
REQ-031 A op 0x20 (illegal) -> a_resp_valid after the next edge; err=1, data=0; alu_opcode unchanged.
REQ-032 rst pulsed in WAIT -> all outputs at REQ-025 values; no response appears afterwards; the next request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, registered-latency ALU.
// Per-requester carry registers keep addc/subc chains intact across interleaved use.
module alu_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic        b_valid,
    output logic        a_ready,
    output logic        b_ready,
    input  logic [7:0]  a_rd,
    input  logic [7:0]  a_rr,
    input  logic [7:0]  a_op,
    input  logic [7:0]  b_rd,
    input  logic [7:0]  b_rr,
    input  logic [7:0]  b_op,
    output logic        a_resp_valid,
    output logic        b_resp_valid,
    input  logic        a_resp_ready,
    input  logic        b_resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_c,
    output logic        resp_n,
    output logic        resp_z,
    output logic        resp_err,
    output logic [7:0]  alu_rd,
    output logic [7:0]  alu_rr,
    output logic [7:0]  alu_opcode,
    output logic        alu_ci,
    input  logic [15:0] alu_data,
    input  logic        alu_co,
    input  logic        alu_no,
    input  logic        alu_zo,
    output logic        busy
);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic          r_owner_b;
    logic          r_last_b;
    logic          r_carry_a;
    logic          r_carry_b;
    logic [15:0]   r_resp_data;
    logic          r_resp_c;
    logic          r_resp_n;
    logic          r_resp_z;
    logic          r_resp_err;
    logic [7:0]    r_alu_rd;
    logic [7:0]    r_alu_rr;
    logic [7:0]    r_alu_op;
    logic          r_alu_ci;
    logic          w_any;
    logic          w_grant_b;
    logic          w_legal;
    logic          w_consume;
    logic          w_cnt_zero;
    logic [7:0]    w_rd;
    logic [7:0]    w_rr;
    logic [7:0]    w_op;

    function automatic logic op_legal(input logic [7:0] op);
        logic ok;
        ok = 1'b0;
        case (op[7:4])
            4'h0, 4'h4, 4'h8, 4'h9, 4'hA,
            4'hC, 4'hD, 4'hE, 4'hF: ok = 1'b1;
            4'hB:                   ok = (op[1:0] == 2'b00);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // B wins when it is alone, or on contention when A was granted last.
    assign w_any      = a_valid | b_valid;
    assign w_grant_b  = b_valid & (~a_valid | ~r_last_b);
    assign w_rd       = w_grant_b ? b_rd : a_rd;
    assign w_rr       = w_grant_b ? b_rr : a_rr;
    assign w_op       = w_grant_b ? b_op : a_op;
    assign w_legal    = op_legal(w_op);
    assign w_consume  = r_owner_b ? b_resp_ready : a_resp_ready;
    assign w_cnt_zero = (r_cnt == {CW{1'b0}});

    assign busy         = (r_state != S_IDLE);
    assign a_resp_valid = (r_state == S_RESP) & ~r_owner_b;
    assign b_resp_valid = (r_state == S_RESP) & r_owner_b;
    assign resp_data    = r_resp_data;
    assign resp_c       = r_resp_c;
    assign resp_n       = r_resp_n;
    assign resp_z       = r_resp_z;
    assign resp_err     = r_resp_err;
    assign alu_rd       = r_alu_rd;
    assign alu_rr       = r_alu_rr;
    assign alu_opcode   = r_alu_op;
    assign alu_ci       = r_alu_ci;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and accept strobes; ready is held low while reset is asserted.
    always_comb begin
        w_state_next = r_state;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && !rst) begin
                    a_ready      = ~w_grant_b;
                    b_ready      = w_grant_b;
                    w_state_next = w_legal ? S_WAIT : S_RESP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = S_RESP;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_RESP: begin
                if (w_consume) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand launch, latency count, response capture and carry bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= {CW{1'b0}};
            r_owner_b   <= 1'b0;
            r_last_b    <= 1'b1;
            r_carry_a   <= 1'b0;
            r_carry_b   <= 1'b0;
            r_resp_data <= 16'h0000;
            r_resp_c    <= 1'b0;
            r_resp_n    <= 1'b0;
            r_resp_z    <= 1'b0;
            r_resp_err  <= 1'b0;
            r_alu_rd    <= 8'h00;
            r_alu_rr    <= 8'h00;
            r_alu_op    <= 8'h00;
            r_alu_ci    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner_b <= w_grant_b;
                        r_last_b  <= w_grant_b;
                        if (w_legal) begin
                            r_alu_rd <= w_rd;
                            r_alu_rr <= w_rr;
                            r_alu_op <= w_op;
                            r_alu_ci <= w_grant_b ? r_carry_b : r_carry_a;
                            r_cnt    <= CW'(LATENCY);
                        end else begin
                            r_resp_data <= 16'h0000;
                            r_resp_c    <= 1'b0;
                            r_resp_n    <= 1'b0;
                            r_resp_z    <= 1'b0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_cnt_zero) begin
                        r_resp_data <= alu_data;
                        r_resp_c    <= alu_co;
                        r_resp_n    <= alu_no;
                        r_resp_z    <= alu_zo;
                        r_resp_err  <= 1'b0;
                        if (r_owner_b) begin
                            r_carry_b <= alu_co;
                        end else begin
                            r_carry_a <= alu_co;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU fixture, transaction-level reference
// model (grant history, per-requester carry, launched operands), directed + random steps.
module tb_alu_arbiter;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [7:0]  a_rd = 8'h00, a_rr = 8'h00, a_op = 8'h00;
    logic [7:0]  b_rd = 8'h00, b_rr = 8'h00, b_op = 8'h00;
    logic        a_resp_valid, b_resp_valid;
    logic        a_resp_ready = 1'b0, b_resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_c, resp_n, resp_z, resp_err;
    logic [7:0]  alu_rd, alu_rr, alu_opcode;
    logic        alu_ci;
    logic [15:0] alu_data;
    logic        alu_co, alu_no, alu_zo;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_last_b;
    logic [1:0] m_carry;
    logic [7:0] m_rd, m_rr, m_op;
    logic       m_ci;

    always #5 clk = ~clk;

    alu_arbiter #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .a_rd(a_rd), .a_rr(a_rr), .a_op(a_op), .b_rd(b_rd), .b_rr(b_rr), .b_op(b_op),
        .a_resp_valid(a_resp_valid), .b_resp_valid(b_resp_valid),
        .a_resp_ready(a_resp_ready), .b_resp_ready(b_resp_ready),
        .resp_data(resp_data), .resp_c(resp_c), .resp_n(resp_n), .resp_z(resp_z),
        .resp_err(resp_err),
        .alu_rd(alu_rd), .alu_rr(alu_rr), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
        .alu_data(alu_data), .alu_co(alu_co), .alu_no(alu_no), .alu_zo(alu_zo),
        .busy(busy)
    );

    // Behavioural ALU: returns {c, n, z, data}
    function automatic logic [18:0] alu_ref(input logic [7:0] op, input logic [7:0] rd,
                                            input logic [7:0] rr, input logic ci);
        int s;
        logic [15:0] d;
        logic c, n;
        case (op[7:4])
            4'hC:    begin s = rd + rr;      d = {8'h00, 8'(s)}; c = (s > 255); n = d[7]; end
            4'hD:    begin s = rd + rr + ci; d = {8'h00, 8'(s)}; c = (s > 255); n = d[7]; end
            4'h4:    begin d = 16'(rd * rr); c = 1'b0; n = d[15]; end
            default: begin d = {8'h00, rd ^ rr}; c = 1'b0; n = d[7]; end
        endcase
        return {c, n, (d == 16'h0000), d};
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return (op ==? 8'b0000????) || (op ==? 8'b0100????) || (op ==? 8'b1000????) ||
               (op ==? 8'b1001????) || (op ==? 8'b1010????) || (op ==? 8'b1011??00) ||
               (op ==? 8'b11??????);
    endfunction

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 8'($urandom_range(0, 255));
            1:       return {4'hC, 4'($urandom_range(0, 15))};
            2:       return {4'hD, 4'($urandom_range(0, 15))};
            3:       return {4'h4, 4'($urandom_range(0, 15))};
            default: return {4'hB, 4'($urandom_range(0, 15))};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        {alu_co, alu_no, alu_zo, alu_data} <= alu_ref(alu_opcode, alu_rd, alu_rr, alu_ci);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_carry  = 2'b00;
        m_rd     = 8'h00;
        m_rr     = 8'h00;
        m_op     = 8'h00;
        m_ci     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, {a_ready, b_ready}, 2'b00);
        check({tag, "_rvalid"}, {a_resp_valid, b_resp_valid}, 2'b00);
        check({tag, "_resp"}, {resp_err, resp_c, resp_n, resp_z, resp_data}, 20'h0);
        check({tag, "_alu"}, {alu_ci, alu_opcode, alu_rd, alu_rr}, 25'h0);
    endtask

    // One transaction from an IDLE cycle through consumption of the response.
    // got = {err, c, n, z, data}
    task automatic txn(input logic av, input logic bv,
                       input logic [7:0] ard, input logic [7:0] arr, input logic [7:0] aop,
                       input logic [7:0] brd, input logic [7:0] brr, input logic [7:0] bop,
                       input logic hold_loser, output logic [19:0] got);
        logic win_b, legal;
        logic [7:0] rd, rr, op;
        logic [19:0] exp;
        int k;
        a_valid = av; b_valid = bv;
        a_rd = ard; a_rr = arr; a_op = aop;
        b_rd = brd; b_rr = brr; b_op = bop;
        #1;
        win_b = (av && bv) ? !m_last_b : bv;
        check("busy_idle", busy, 1'b0);
        check("grant", {a_ready, b_ready}, {!win_b, win_b});
        rd = win_b ? brd : ard;
        rr = win_b ? brr : arr;
        op = win_b ? bop : aop;
        legal = is_legal(op);
        @(posedge clk); #1;
        if (!hold_loser) begin
            a_valid = 1'b0; b_valid = 1'b0;
        end else if (win_b) begin
            b_valid = 1'b0;
        end else begin
            a_valid = 1'b0;
        end
        m_last_b = win_b;
        if (legal) begin
            m_rd = rd; m_rr = rr; m_op = op; m_ci = m_carry[win_b];
            exp = {1'b0, alu_ref(op, rd, rr, m_ci)};
        end else begin
            exp = {1'b1, 19'h0};
        end
        check("alu_regs", {alu_ci, alu_opcode, alu_rd, alu_rr}, {m_ci, m_op, m_rd, m_rr});
        k = 0;
        while (!(a_resp_valid || b_resp_valid) && k < 20) begin
            if (hold_loser) check("loser_ready", win_b ? a_ready : b_ready, 1'b0);
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, legal ? LATENCY + 1 : 0);
        check("resp_owner", {a_resp_valid, b_resp_valid}, {!win_b, win_b});
        got = {resp_err, resp_c, resp_n, resp_z, resp_data};
        check("resp", got, exp);
        if (legal) m_carry[win_b] = exp[18];
        if (win_b) a_resp_ready = 1'b1; else b_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0; b_resp_ready = 1'b0;
        check("nonowner_ignored", {a_resp_valid, b_resp_valid, resp_err, resp_c, resp_n, resp_z, resp_data},
              {!win_b, win_b, exp});
        if (win_b) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0; b_resp_ready = 1'b0;
        check("consumed", {busy, a_resp_valid, b_resp_valid}, 3'b000);
    endtask

    initial begin
        logic [19:0] got;
        model_reset();
        // Both requesters valid straight out of reset
        a_valid = 1'b1; b_valid = 1'b1;
        a_rd = 8'h7F; a_rr = 8'h01; a_op = 8'hC0;
        b_rd = 8'h05; b_rr = 8'h03; b_op = 8'hC0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b1, 1'b1, 8'h7F, 8'h01, 8'hC0, 8'h05, 8'h03, 8'hC0, 1'b1, got);
        check("add_7f_01", got, {1'b0, 1'b0, 1'b1, 1'b0, 16'h0080});
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h05, 8'h03, 8'hC0, 1'b0, got);
        check("b_after_a", got[15:0], 16'h0008);

        txn(1'b1, 1'b0, 8'h10, 8'h10, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, got);
        check("mult", {got[19], got[15:0]}, {1'b0, 16'h0100});

        // Carry chain across interleaved requesters
        txn(1'b1, 1'b0, 8'hFF, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h00, 1'b0, got);
        check("add_ff_01", {got[18], got[16], got[15:0]}, {1'b1, 1'b1, 16'h0000});
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'hC0, 1'b0, got);
        check("b_add", {got[18], got[15:0]}, {1'b0, 16'h0002});
        txn(1'b1, 1'b0, 8'h00, 8'h00, 8'hD0, 8'h00, 8'h00, 8'h00, 1'b0, got);
        check("addc_ci", alu_ci, 1'b1);
        check("addc", got[15:0], 16'h0001);

        // Illegal opcodes leave the ALU untouched
        txn(1'b1, 1'b0, 8'h12, 8'h34, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, got);
        check("illegal_20", got, {1'b1, 19'h0});
        check("illegal_opcode_kept", alu_opcode, 8'hD0);
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'hB1, 1'b0, got);
        check("illegal_b1", got[19], 1'b1);
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'hB4, 1'b0, got);
        check("legal_b4", got[19], 1'b0);

        // Round robin under contention
        txn(1'b1, 1'b1, 8'h01, 8'h01, 8'hC0, 8'h02, 8'h02, 8'hC0, 1'b0, got);
        txn(1'b1, 1'b1, 8'h01, 8'h01, 8'hC0, 8'h02, 8'h02, 8'hC0, 1'b0, got);

        // Reset in the middle of WAIT
        a_valid = 1'b1; a_rd = 8'h33; a_rr = 8'h44; a_op = 8'hC0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("in_wait", busy, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("rst_wait");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_resp_after_rst", {busy, a_resp_valid, b_resp_valid}, 3'b000);
        end
        txn(1'b1, 1'b1, 8'h01, 8'h02, 8'hC0, 8'h09, 8'h09, 8'hC0, 1'b0, got);
        check("post_rst", got, {4'b0000, 16'h0003});

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic av, bv;
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            if (!av && !bv) av = 1'b1;
            txn(av, bv, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op(),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op(),
                1'($urandom_range(0, 1)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
